// File: rtl/inst_buffer.sv
// Instruction FIFO between the fetch and issue stages.
// Accepts up to two fetched instructions per cycle, presents the two oldest
// entries to issue, and retires 0/1/2 entries per cycle as issue reports.
// A branch flush empties the buffer and has priority over push and pop.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 131
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [1:0]       fetch_valid_i,
    input  logic [WIDTH-1:0] fetch_inst1_bus_i,
    input  logic [WIDTH-1:0] fetch_inst2_bus_i,
    output logic             buffer_allowin_o,
    input  logic [1:0]       issue_mode_i,
    output logic [1:0]       instbuffer_count_o,
    output logic [WIDTH-1:0] inst1_bus_o,
    output logic [WIDTH-1:0] inst2_bus_o
);

    localparam int AW = $clog2(DEPTH);
    // Extra MSB on the pointers separates full from empty.
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        NO_ISSUE     = 2'b00,
        SINGLE_ISSUE = 2'b01,
        DOUBLE_ISSUE = 2'b10
    } issue_mode_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    entries;
    logic [PW-1:0]    rd2_ptr;
    logic [PW-1:0]    wr2_ptr;
    logic [1:0]       push_cnt;
    logic [1:0]       pop_req;
    logic [1:0]       pop_cnt;

    // Occupancy, accept/retire counts and the read-side view of the two oldest entries.
    always_comb begin
        entries          = tail - head;
        rd2_ptr          = head + PW'(1);
        wr2_ptr          = tail + PW'(1);
        buffer_allowin_o = (entries <= PW'(DEPTH - 2));

        // 10 is an illegal fetch pattern and pushes nothing.
        push_cnt = 2'd0;
        if (buffer_allowin_o) begin
            case (fetch_valid_i)
                2'b01:   push_cnt = 2'd1;
                2'b11:   push_cnt = 2'd2;
                default: push_cnt = 2'd0;
            endcase
        end

        case (issue_mode_t'(issue_mode_i))
            SINGLE_ISSUE: pop_req = 2'd1;
            DOUBLE_ISSUE: pop_req = 2'd2;
            default:      pop_req = 2'd0;
        endcase

        // Saturate retirement to what is actually buffered; when the request
        // exceeds occupancy, occupancy is below two so its low bits suffice.
        if (PW'(pop_req) > entries) begin
            pop_cnt = entries[1:0];
        end else begin
            pop_cnt = pop_req;
        end

        inst1_bus_o        = '0;
        inst2_bus_o        = '0;
        instbuffer_count_o = 2'b00;
        if (entries != '0) begin
            inst1_bus_o        = mem[head[AW-1:0]];
            instbuffer_count_o = 2'b01;
        end
        if (entries > PW'(1)) begin
            inst2_bus_o        = mem[rd2_ptr[AW-1:0]];
            instbuffer_count_o = 2'b10;
        end
    end

    // Storage write: inst1 lands at tail, inst2 at the slot after it.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (push_cnt != 2'd0) begin
                mem[tail[AW-1:0]] <= fetch_inst1_bus_i;
            end
            if (push_cnt == 2'd2) begin
                mem[wr2_ptr[AW-1:0]] <= fetch_inst2_bus_i;
            end
        end
    end

    // Pointer update; flush discards any same-cycle push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + PW'(pop_cnt);
            tail <= tail + PW'(push_cnt);
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH=16, WIDTH=131).
module tb_inst_buffer;

    localparam int DEPTH = 16;
    localparam int WIDTH = 131;

    logic             clk;
    logic             rst;
    logic             flush_i;
    logic [1:0]       fetch_valid_i;
    logic [WIDTH-1:0] fetch_inst1_bus_i;
    logic [WIDTH-1:0] fetch_inst2_bus_i;
    logic             buffer_allowin_o;
    logic [1:0]       issue_mode_i;
    logic [1:0]       instbuffer_count_o;
    logic [WIDTH-1:0] inst1_bus_o;
    logic [WIDTH-1:0] inst2_bus_o;

    int checks   = 0;
    int failures = 0;

    inst_buffer #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_inst1_bus_i (fetch_inst1_bus_i),
        .fetch_inst2_bus_i (fetch_inst2_bus_i),
        .buffer_allowin_o  (buffer_allowin_o),
        .issue_mode_i      (issue_mode_i),
        .instbuffer_count_o(instbuffer_count_o),
        .inst1_bus_o       (inst1_bus_o),
        .inst2_bus_o       (inst2_bus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tagged instruction: top bits vary with the tag so the full width is exercised.
    function automatic logic [WIDTH-1:0] mk(input int n);
        logic [2:0] hi;
        hi = 3'(n % 8);
        return {hi, 96'h5A5A5A5A_A5A5A5A5_3C3C3C3C, 32'(n)};
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [1:0] mode);
        fetch_valid_i     = v;
        fetch_inst1_bus_i = a;
        fetch_inst2_bus_i = b;
        issue_mode_i      = mode;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] cnt, input logic [WIDTH-1:0] i1,
                             input logic [WIDTH-1:0] i2, input logic allow);
        chk({tag, "_count"}, WIDTH'(instbuffer_count_o), WIDTH'(cnt));
        chk({tag, "_inst1"}, inst1_bus_o, i1);
        chk({tag, "_inst2"}, inst2_bus_o, i2);
        chk({tag, "_allowin"}, WIDTH'(buffer_allowin_o), WIDTH'(allow));
    endtask

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] issued[$];
    logic [WIDTH-1:0] zero_bus;
    int               next_tag;
    int               pushed;
    int               npush;
    int               npop;
    int               req;
    logic [1:0]       v;
    logic [1:0]       ecnt;
    int               issue_pat[8] = '{1, 0, 2, 1, 2, 0, 1, 2};

    initial begin
        zero_bus = '0;
        rst      = 1'b0;
        flush_i  = 1'b0;
        drive(2'b00, '0, '0, 2'b00);

        // Power-on reset asserted before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk_state("por", 2'b00, zero_bus, zero_bus, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Dual push with no issue, then a dual retire.
        drive(2'b11, mk(1), mk(2), 2'b00);
        step();
        chk_state("dual_push", 2'b10, mk(1), mk(2), 1'b1);
        drive(2'b00, '0, '0, 2'b10);
        step();
        chk_state("dual_pop", 2'b00, zero_bus, zero_bus, 1'b1);

        // Single push, then push two while retiring one.
        drive(2'b01, mk(3), mk(99), 2'b00);
        step();
        chk_state("single_push", 2'b01, mk(3), zero_bus, 1'b1);
        drive(2'b11, mk(4), mk(5), 2'b01);
        step();
        chk_state("push_pop", 2'b10, mk(4), mk(5), 1'b1);

        // Asynchronous reset in mid-cycle clears outputs without a clock edge.
        drive(2'b00, '0, '0, 2'b00);
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", 2'b00, zero_bus, zero_bus, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Fill without popping: 7 dual pushes keep allowin high.
        for (int k = 0; k < 7; k++) begin
            drive(2'b11, mk(100 + 2 * k), mk(101 + 2 * k), 2'b00);
            step();
        end
        chk_state("fill14", 2'b10, mk(100), mk(101), 1'b1);
        drive(2'b11, mk(114), mk(115), 2'b00);
        step();
        chk_state("fill16", 2'b10, mk(100), mk(101), 1'b0);
        drive(2'b11, mk(116), mk(117), 2'b00);
        step();
        chk_state("drop_push", 2'b10, mk(100), mk(101), 1'b0);
        drive(2'b00, '0, '0, 2'b10);
        step();
        chk_state("unfull", 2'b10, mk(102), mk(103), 1'b1);
        // Drain, checking FIFO order; the dropped 116/117 must never appear.
        for (int k = 0; k < 7; k++) begin
            chk("drain_inst1", inst1_bus_o, mk(102 + 2 * k));
            chk("drain_inst2", inst2_bus_o, mk(103 + 2 * k));
            step();
        end
        chk_state("drained", 2'b00, zero_bus, zero_bus, 1'b1);

        // Stream 40 tags through a wrapping buffer with mixed retire widths.
        q.delete();
        issued.delete();
        next_tag = 200;
        pushed   = 0;
        for (int c = 0; c < 300 && issued.size() < 40; c++) begin
            ecnt = (q.size() == 0) ? 2'b00 : (q.size() == 1) ? 2'b01 : 2'b10;
            chk("wrap_count", WIDTH'(instbuffer_count_o), WIDTH'(ecnt));
            chk("wrap_inst1", inst1_bus_o, (q.size() >= 1) ? q[0] : zero_bus);
            chk("wrap_inst2", inst2_bus_o, (q.size() >= 2) ? q[1] : zero_bus);
            chk("wrap_allowin", WIDTH'(buffer_allowin_o), WIDTH'(DEPTH - q.size() >= 2));

            if (40 - pushed >= 2 && (c % 3) != 1) v = 2'b11;
            else if (40 - pushed >= 1) v = 2'b01;
            else v = 2'b00;
            req = issue_pat[c % 8];
            drive(v, mk(next_tag), mk(next_tag + 1), 2'(req));

            npop = (req < q.size()) ? req : q.size();
            if (npop >= 1) issued.push_back(inst1_bus_o);
            if (npop >= 2) issued.push_back(inst2_bus_o);
            for (int p = 0; p < npop; p++) void'(q.pop_front());

            npush = 0;
            if (DEPTH - (q.size() + npop) >= 2) npush = (v == 2'b11) ? 2 : (v == 2'b01) ? 1 : 0;
            for (int p = 0; p < npush; p++) q.push_back(mk(next_tag + p));
            next_tag += npush;
            pushed   += npush;
            step();
        end
        chk("wrap_issued_total", WIDTH'(issued.size()), WIDTH'(40));
        for (int i = 0; i < 40 && i < issued.size(); i++) begin
            chk("wrap_order", issued[i], mk(200 + i));
        end
        drive(2'b00, '0, '0, 2'b00);
        step();
        chk_state("wrap_empty", 2'b00, zero_bus, zero_bus, 1'b1);

        // Build five entries, then flush with a simultaneous push and dual retire.
        drive(2'b11, mk(300), mk(301), 2'b00);
        step();
        drive(2'b11, mk(302), mk(303), 2'b00);
        step();
        drive(2'b01, mk(304), mk(0), 2'b00);
        step();
        chk_state("pre_flush", 2'b10, mk(300), mk(301), 1'b1);
        flush_i = 1'b1;
        drive(2'b11, mk(305), mk(306), 2'b10);
        step();
        flush_i = 1'b0;
        drive(2'b00, '0, '0, 2'b00);
        chk_state("flush", 2'b00, zero_bus, zero_bus, 1'b1);
        step();
        chk_state("flush_hold", 2'b00, zero_bus, zero_bus, 1'b1);

        // Dual retire against a single entry must not underflow.
        drive(2'b01, mk(400), mk(0), 2'b00);
        step();
        chk_state("one_entry", 2'b01, mk(400), zero_bus, 1'b1);
        drive(2'b00, '0, '0, 2'b10);
        step();
        chk_state("over_pop", 2'b00, zero_bus, zero_bus, 1'b1);
        step();
        chk_state("over_pop_empty", 2'b00, zero_bus, zero_bus, 1'b1);
        drive(2'b11, mk(401), mk(402), 2'b00);
        step();
        chk_state("post_underflow", 2'b10, mk(401), mk(402), 1'b1);

        // Illegal fetch pattern 10 and issue mode 11 do nothing.
        drive(2'b10, mk(403), mk(404), 2'b00);
        step();
        chk_state("illegal_valid", 2'b10, mk(401), mk(402), 1'b1);
        drive(2'b00, '0, '0, 2'b11);
        step();
        chk_state("illegal_issue", 2'b10, mk(401), mk(402), 1'b1);
        drive(2'b00, '0, '0, 2'b01);
        step();
        chk_state("single_retire", 2'b01, mk(402), zero_bus, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
